// File: rtl/palette_bank.sv
// Runtime-writable multi-bank colour palette with a registered lookup pipeline and frame-aligned bank swap.
// Optional macro PALETTE_FADE_EN adds a fadeLevel input and a brightness-scaling third stage.
module palette_bank #(
  parameter int IDX_W     = 4,
  parameter int COLOR_W   = 24,
  parameter int NUM_BANKS = 2,
  parameter int KEY_IDX   = 0,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               rdValid,
  input  logic [IDX_W-1:0]   colorIdx,
  output logic [COLOR_W-1:0] rgbVal,
  output logic               rgbValid,
  output logic               transparent,
  input  logic               wrEn,
  input  logic [BANK_W-1:0]  wrBank,
  input  logic [IDX_W-1:0]   wrIdx,
  input  logic [COLOR_W-1:0] wrData,
  input  logic [BANK_W-1:0]  bankSel,
  input  logic               frameStart,
  output logic [BANK_W-1:0]  activeBank
`ifdef PALETTE_FADE_EN
  ,
  input  logic [3:0]         fadeLevel
`endif
);

  localparam int DEPTH      = 2 ** IDX_W;
  localparam int BANK_SLOTS = 2 ** BANK_W;
  localparam int TW         = COLOR_W + 24;
  localparam int SH_UP      = (COLOR_W >= 24) ? COLOR_W - 24 : 0;
  localparam int SH_DN      = (COLOR_W < 24) ? 24 - COLOR_W : 0;

  function automatic logic [23:0] defaultRgb24(input int unsigned idx);
    case (idx)
      0:       return 24'hFF00FF;
      1:       return 24'hFFFFFF;
      2:       return 24'h7A7A7A;
      3:       return 24'h2D2D2D;
      4:       return 24'hFF4234;
      5:       return 24'h1C43DC;
      6:       return 24'hA31313;
      7:       return 24'hEFFF6E;
      8:       return 24'h359FE9;
      9:       return 24'h136096;
      10:      return 24'h0C4065;
      11:      return 24'h96C03D;
      12:      return 24'h3A572B;
      13:      return 24'h272233;
      14:      return 24'hABCCF3;
      15:      return 24'hE21A1A;
      default: return '0;
    endcase
  endfunction

  // Defaults are 24-bit; wider colours pad LSBs with zeros, narrower drop LSBs.
  function automatic logic [COLOR_W-1:0] defaultColor(input int unsigned idx);
    logic [TW-1:0] t;
    t = TW'(defaultRgb24(idx));
    t = (t << SH_UP) >> SH_DN;
    return t[COLOR_W-1:0];
  endfunction

  function automatic logic [BANK_SLOTS-1:0] bankMask();
    logic [BANK_SLOTS-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < BANK_SLOTS; b++) begin
      m[b] = (b < unsigned'(NUM_BANKS));
    end
    return m;
  endfunction

  localparam logic [BANK_SLOTS-1:0] BANK_OK = bankMask();

  logic [COLOR_W-1:0] mem [NUM_BANKS][DEPTH];

  logic               s1Valid;
  logic [IDX_W-1:0]   s1Idx;
  logic [BANK_W-1:0]  s1Bank;
  logic [COLOR_W-1:0] rdColor;
  logic               keyHit;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int unsigned b = 0; b < unsigned'(NUM_BANKS); b++) begin
        for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
          mem[b][i] <= defaultColor(i);
        end
      end
    end else if (wrEn && BANK_OK[wrBank]) begin
      mem[wrBank][wrIdx] <= wrData;
    end
  end

  // Stage 1 latches the bank before any swap on the same edge takes effect.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1Valid    <= 1'b0;
      s1Idx      <= '0;
      s1Bank     <= '0;
      activeBank <= '0;
    end else begin
      s1Valid <= rdValid;
      s1Idx   <= colorIdx;
      s1Bank  <= activeBank;
      if (frameStart && BANK_OK[bankSel]) begin
        activeBank <= bankSel;
      end
    end
  end

  always_comb begin
    rdColor = mem[s1Bank][s1Idx];
    keyHit  = (s1Idx == IDX_W'(KEY_IDX));
  end

`ifdef PALETTE_FADE_EN
  localparam int CH_W = COLOR_W / 3;
  localparam int PW   = CH_W + 4;

  logic               s2Valid;
  logic [COLOR_W-1:0] s2Color;
  logic               s2Key;
  logic [3:0]         s2Fade;
  logic [COLOR_W-1:0] faded;
  logic [PW-1:0]      prod;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s2Valid <= 1'b0;
      s2Color <= '0;
      s2Key   <= 1'b0;
      s2Fade  <= '0;
    end else begin
      s2Valid <= s1Valid;
      s2Color <= s1Valid ? rdColor : '0;
      s2Key   <= s1Valid & keyHit;
      s2Fade  <= fadeLevel;
    end
  end

  // Scale factor is fadeLevel+1 sixteenths, so level 15 passes colour through.
  always_comb begin
    faded = '0;
    prod  = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      prod = PW'(s2Color[c*CH_W +: CH_W]) * (PW'(s2Fade) + PW'(1));
      faded[c*CH_W +: CH_W] = prod[PW-1:4];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rgbValid    <= 1'b0;
      rgbVal      <= '0;
      transparent <= 1'b0;
    end else begin
      rgbValid    <= s2Valid;
      rgbVal      <= s2Valid ? faded : '0;
      transparent <= s2Valid & s2Key;
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rgbValid    <= 1'b0;
      rgbVal      <= '0;
      transparent <= 1'b0;
    end else begin
      rgbValid    <= s1Valid;
      rgbVal      <= s1Valid ? rdColor : '0;
      transparent <= s1Valid & keyHit;
    end
  end
`endif

endmodule

// File: tb/tb_palette_bank.sv
// Scoreboard bench for palette_bank: driver queues expected lookups, a monitor checks every cycle.
// Honours PALETTE_FADE_EN to match the DUT build.
module tb_palette_bank;

`ifdef PALETTE_FADE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        rdValid;
  logic [3:0]  colorIdx;
  logic [23:0] rgbVal;
  logic        rgbValid;
  logic        transparent;
  logic        wrEn;
  logic [0:0]  wrBank;
  logic [3:0]  wrIdx;
  logic [23:0] wrData;
  logic [0:0]  bankSel;
  logic        frameStart;
  logic [0:0]  activeBank;
  logic [3:0]  fadeLevel;

  always #5 Clk = ~Clk;

  palette_bank #(
    .IDX_W(4),
    .COLOR_W(24),
    .NUM_BANKS(2),
    .KEY_IDX(0)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .rdValid(rdValid),
    .colorIdx(colorIdx),
    .rgbVal(rgbVal),
    .rgbValid(rgbValid),
    .transparent(transparent),
    .wrEn(wrEn),
    .wrBank(wrBank),
    .wrIdx(wrIdx),
    .wrData(wrData),
    .bankSel(bankSel),
    .frameStart(frameStart),
`ifdef PALETTE_FADE_EN
    .fadeLevel(fadeLevel),
`endif
    .activeBank(activeBank)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        key;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   monEn = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin : monitor
    exp_t e;
    logic expV;
    if (monEn) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL timeout: result due cycle %0d still pending at cycle %0d", e.due, cyc);
      end
      expV = (sbq.size() > 0) && (sbq[0].due == cyc);
      total++;
      if (rgbValid !== expV) begin
        bad++;
        $display("FAIL rgbValid @%0d: got %b want %b", cyc, rgbValid, expV);
      end
      if (expV) begin
        e = sbq.pop_front();
        total++;
        if (rgbVal !== e.rgb || transparent !== e.key) begin
          bad++;
          $display("FAIL lookup @%0d: got rgb=%06h tr=%b want rgb=%06h tr=%b",
                   cyc, rgbVal, transparent, e.rgb, e.key);
        end
      end else begin
        total++;
        if (rgbVal !== 24'h0 || transparent !== 1'b0) begin
          bad++;
          $display("FAIL idle @%0d: got rgb=%06h tr=%b want rgb=000000 tr=0",
                   cyc, rgbVal, transparent);
        end
      end
    end
  end

  task automatic nextCyc();
    @(posedge Clk);
    #1;
    rdValid    = 1'b0;
    wrEn       = 1'b0;
    frameStart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) nextCyc();
  endtask

  task automatic issue(input logic [3:0] idx, input logic [23:0] rgb, input logic key);
    exp_t e;
    rdValid  = 1'b1;
    colorIdx = idx;
    e.rgb    = rgb;
    e.key    = key;
    e.due    = cyc + LAT;
    sbq.push_back(e);
  endtask

  task automatic writeEntry(input logic [0:0] bank, input logic [3:0] idx, input logic [23:0] data);
    wrEn   = 1'b1;
    wrBank = bank;
    wrIdx  = idx;
    wrData = data;
  endtask

  task automatic checkBank(input string name, input logic [0:0] want);
    total++;
    if (activeBank !== want) begin
      bad++;
      $display("FAIL %s: activeBank=%0d want %0d", name, activeBank, want);
    end
  endtask

  // Results due on or after the reset edge never leave the pipeline.
  task automatic flushFrom(input int r);
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].due >= r) sbq.delete(k);
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    rdValid    = 1'b0;
    colorIdx   = '0;
    wrEn       = 1'b0;
    wrBank     = '0;
    wrIdx      = '0;
    wrData     = '0;
    bankSel    = '0;
    frameStart = 1'b0;
    fadeLevel  = 4'd15;
    idle(2);
    monEn   = 1'b1;
    Reset_n = 1'b1;
    checkBank("resetBank", 1'b0);

    issue(4'd1, 24'hFFFFFF, 1'b0); nextCyc();
    issue(4'd0, 24'hFF00FF, 1'b1); nextCyc();
    idle(LAT + 1);

    issue(4'd4, 24'hFF4234, 1'b0); nextCyc();
    issue(4'd5, 24'h1C43DC, 1'b0); nextCyc();
    issue(4'd6, 24'hA31313, 1'b0); nextCyc();
    idle(LAT + 1);

    // Read of idx4 reaches stage 2 on the same edge the write lands.
    issue(4'd4, 24'hFF4234, 1'b0); nextCyc();
    writeEntry(1'b0, 4'd4, 24'h123456);
    issue(4'd4, 24'h123456, 1'b0); nextCyc();
    issue(4'd4, 24'h123456, 1'b0); nextCyc();
    idle(LAT + 1);

    writeEntry(1'b1, 4'd2, 24'h00FF00); nextCyc();
    bankSel = 1'b1; nextCyc();
    issue(4'd2, 24'h7A7A7A, 1'b0); nextCyc();
    idle(LAT + 1);
    checkBank("noFrameStart", 1'b0);
    frameStart = 1'b1;
    issue(4'd2, 24'h7A7A7A, 1'b0); nextCyc();
    checkBank("swap", 1'b1);
    issue(4'd2, 24'h00FF00, 1'b0); nextCyc();
    issue(4'd4, 24'hFF4234, 1'b0); nextCyc();
    idle(LAT + 1);

    issue(4'd4, 24'hFF4234, 1'b0); nextCyc();
    issue(4'd5, 24'h1C43DC, 1'b0); nextCyc();
    Reset_n = 1'b0;
    flushFrom(cyc + 1);
    nextCyc();
    Reset_n = 1'b1;
    checkBank("afterReset", 1'b0);
    issue(4'd4, 24'hFF4234, 1'b0); nextCyc();
    frameStart = 1'b1; nextCyc();
    checkBank("reswap", 1'b1);
    issue(4'd2, 24'h7A7A7A, 1'b0); nextCyc();
    idle(LAT + 1);

`ifdef PALETTE_FADE_EN
    fadeLevel = 4'd7;
    issue(4'd1, 24'h7F7F7F, 1'b0); nextCyc();
    issue(4'd5, 24'h0E216E, 1'b0); nextCyc();
    idle(LAT + 1);
    fadeLevel = 4'd0;
    issue(4'd0, 24'h0F000F, 1'b1); nextCyc();
    idle(LAT + 1);
    fadeLevel = 4'd15;
    issue(4'd1, 24'hFFFFFF, 1'b0); nextCyc();
    idle(LAT + 1);
`endif

    idle(2);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d results never seen, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
